// File: rtl/dot_product_unit_pkg.sv
// Shared definitions for the dot-product coprocessor: controller state encoding,
// layout of the packed matrix-shape word, and the default datapath width.
package dot_product_unit_pkg;

   localparam int DP_DATA_WIDTH = 32;

   // Each shape field of the config word is one byte.
   localparam int CFG_FIELD_W    = 8;
   localparam int CFG_A_ROWS_LSB = 0;
   localparam int CFG_A_COLS_LSB = 8;
   localparam int CFG_B_ROWS_LSB = 16;
   localparam int CFG_B_COLS_LSB = 24;

   typedef enum logic [2:0] {
      IDLE,
      READ_A,
      READ_B,
      MAC,
      WRITE
   } dp_state_e;

   function automatic logic [CFG_FIELD_W-1:0] cfg_field(input logic [31:0] cfg,
                                                        input int          lsb);
      return cfg[lsb +: CFG_FIELD_W];
   endfunction

endpackage

// File: rtl/dot_product_unit_mac_unit.sv
// Signed multiply-accumulate; the running sum wraps at WIDTH bits.
import dot_product_unit_pkg::*;

module mac_unit #(
   parameter int WIDTH = DP_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    enable,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] acc
);

   // The low WIDTH bits of a signed product and of the wrapped sum are exactly
   // what a WIDTH-bit context yields, so the truncation needs no explicit slice.
   // NOTE: state registers use non-blocking assignment so every flop samples
   // values from before the clock edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + a * b;
      end
   end

endmodule

// File: rtl/dot_product_unit.sv
// Computes one element C[r][c] of a matrix product by streaming row r of A and
// column c of B from word-addressed memory, then writing the sum back.
import dot_product_unit_pkg::*;

module dot_product_unit #(
   parameter int          DATA_WIDTH = DP_DATA_WIDTH,
   parameter logic [31:0] A_BASE     = 32'h0000_0000,
   parameter logic [31:0] B_BASE     = 32'h0000_0400,
   parameter logic [31:0] C_BASE     = 32'h0000_0800
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic [31:0]           i_Config,
   input  logic                  i_Indexes_Ready,
   input  logic [7:0]            i_Row_Index,
   input  logic [7:0]            i_Column_Index,
   output logic                  o_Indexes_Received,
   output logic                  o_Result_Ready,
   output logic                  o_Mem_Read_Enable,
   output logic [31:0]           o_Mem_Read_Address,
   input  logic [DATA_WIDTH-1:0] i_Mem_Read_Data,
   output logic                  o_Mem_Write_Enable,
   output logic [31:0]           o_Mem_Write_Address,
   output logic [DATA_WIDTH-1:0] o_Mem_Write_Data,
   output logic                  o_Error
);

   dp_state_e             state_q, state_d;
   logic [7:0]            row_q, row_d;
   logic [7:0]            col_q, col_d;
   logic [7:0]            a_cols_q, a_cols_d;
   logic [7:0]            b_cols_q, b_cols_d;
   logic [7:0]            k_q, k_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic                  ready_q, ready_d;
   logic                  error_q, error_d;

   logic                  accept;
   logic                  mac_clear;
   logic                  mac_enable;
   logic [DATA_WIDTH-1:0] acc;

   logic [7:0] cfg_a_rows, cfg_a_cols, cfg_b_rows, cfg_b_cols;
   logic       index_in_range;

   assign cfg_a_rows     = cfg_field(i_Config, CFG_A_ROWS_LSB);
   assign cfg_a_cols     = cfg_field(i_Config, CFG_A_COLS_LSB);
   assign cfg_b_rows     = cfg_field(i_Config, CFG_B_ROWS_LSB);
   assign cfg_b_cols     = cfg_field(i_Config, CFG_B_COLS_LSB);
   assign index_in_range = (i_Row_Index < cfg_a_rows) && (i_Column_Index < cfg_b_cols);

   // The acknowledge is combinational, so it is gated by reset to keep it low
   // while the unit is held in reset.
   assign accept = (state_q == IDLE) && i_Indexes_Ready && i_Reset;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d             = state_q;
      row_d               = row_q;
      col_d               = col_q;
      a_cols_d            = a_cols_q;
      b_cols_d            = b_cols_q;
      k_d                 = k_q;
      a_d                 = a_q;
      ready_d             = ready_q;
      error_d             = error_q;
      mac_clear           = 1'b0;
      mac_enable          = 1'b0;
      o_Indexes_Received  = 1'b0;
      o_Mem_Read_Enable   = 1'b0;
      o_Mem_Read_Address  = '0;
      o_Mem_Write_Enable  = 1'b0;
      o_Mem_Write_Address = '0;
      o_Mem_Write_Data    = '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               o_Indexes_Received = 1'b1;
               row_d              = i_Row_Index;
               col_d              = i_Column_Index;
               a_cols_d           = cfg_a_cols;
               b_cols_d           = cfg_b_cols;
               k_d                = '0;
               mac_clear          = 1'b1;
               if (!index_in_range) begin
                  error_d = 1'b1;
                  ready_d = 1'b1;
               end else begin
                  ready_d = 1'b0;
                  if (cfg_a_cols != cfg_b_rows) error_d = 1'b1;
                  state_d = (cfg_a_cols == '0) ? WRITE : READ_A;
               end
            end
         end
         READ_A: begin
            o_Mem_Read_Enable  = 1'b1;
            o_Mem_Read_Address = A_BASE + 32'(row_q) * 32'(a_cols_q) + 32'(k_q);
            state_d            = READ_B;
         end
         READ_B: begin
            a_d                = i_Mem_Read_Data;
            o_Mem_Read_Enable  = 1'b1;
            o_Mem_Read_Address = B_BASE + 32'(k_q) * 32'(b_cols_q) + 32'(col_q);
            state_d            = MAC;
         end
         MAC: begin
            mac_enable = 1'b1;
            k_d        = k_q + 8'd1;
            state_d    = (k_d == a_cols_q) ? WRITE : READ_A;
         end
         WRITE: begin
            o_Mem_Write_Enable  = 1'b1;
            o_Mem_Write_Address = C_BASE + 32'(row_q) * 32'(b_cols_q) + 32'(col_q);
            o_Mem_Write_Data    = acc;
            ready_d             = 1'b1;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q  <= IDLE;
         row_q    <= '0;
         col_q    <= '0;
         a_cols_q <= '0;
         b_cols_q <= '0;
         k_q      <= '0;
         a_q      <= '0;
         ready_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         a_cols_q <= a_cols_d;
         b_cols_q <= b_cols_d;
         k_q      <= k_d;
         a_q      <= a_d;
         ready_q  <= ready_d;
         error_q  <= error_d;
      end
   end

   // B data arrives during MAC and feeds the multiplier directly.
   mac_unit #(.WIDTH(DATA_WIDTH)) u_mac (
      .clk    (i_Clock),
      .rst_n  (i_Reset),
      .clear  (mac_clear),
      .enable (mac_enable),
      .a      (a_q),
      .b      (i_Mem_Read_Data),
      .acc    (acc)
   );

   assign o_Result_Ready = ready_q;
   assign o_Error        = error_q;

endmodule

// File: tb/tb_dot_product_unit.sv
// Self-checking bench for dot_product_unit: directed and random matrix elements
// compared against a plain-arithmetic dot-product model and a memory model.
module tb_dot_product_unit;

   localparam logic [31:0] A_BASE = 32'h0000_0000;
   localparam logic [31:0] B_BASE = 32'h0000_0400;
   localparam logic [31:0] C_BASE = 32'h0000_0800;

   logic        clk = 1'b0;
   logic        i_Reset;
   logic [31:0] i_Config;
   logic        i_Indexes_Ready;
   logic [7:0]  i_Row_Index;
   logic [7:0]  i_Column_Index;
   logic        o_Indexes_Received;
   logic        o_Result_Ready;
   logic        o_Mem_Read_Enable;
   logic [31:0] o_Mem_Read_Address;
   logic [31:0] i_Mem_Read_Data;
   logic        o_Mem_Write_Enable;
   logic [31:0] o_Mem_Write_Address;
   logic [31:0] o_Mem_Write_Data;
   logic        o_Error;

   int          vectors    = 0;
   int          miscompares = 0;
   int          cyc        = 0;
   int          n_reads    = 0;
   int          n_writes   = 0;
   int          w_cyc      = 0;
   logic [31:0] w_addr     = '0;
   logic [31:0] w_data     = '0;
   logic        err_m      = 1'b0;
   int          am [8][8];
   int          bm [8][8];
   logic [31:0] mem [0:4095];

   dot_product_unit #(
      .DATA_WIDTH (32),
      .A_BASE     (A_BASE),
      .B_BASE     (B_BASE),
      .C_BASE     (C_BASE)
   ) dut (
      .i_Clock             (clk),
      .i_Reset             (i_Reset),
      .i_Config            (i_Config),
      .i_Indexes_Ready     (i_Indexes_Ready),
      .i_Row_Index         (i_Row_Index),
      .i_Column_Index      (i_Column_Index),
      .o_Indexes_Received  (o_Indexes_Received),
      .o_Result_Ready      (o_Result_Ready),
      .o_Mem_Read_Enable   (o_Mem_Read_Enable),
      .o_Mem_Read_Address  (o_Mem_Read_Address),
      .i_Mem_Read_Data     (i_Mem_Read_Data),
      .o_Mem_Write_Enable  (o_Mem_Write_Enable),
      .o_Mem_Write_Address (o_Mem_Write_Address),
      .o_Mem_Write_Data    (o_Mem_Write_Data),
      .o_Error             (o_Error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memory: data appears the cycle after a request, junk otherwise.
   always @(posedge clk) begin
      if (o_Mem_Read_Enable) i_Mem_Read_Data <= mem[o_Mem_Read_Address[11:0]];
      else                   i_Mem_Read_Data <= $urandom;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      check("enables_exclusive", 32'(o_Mem_Read_Enable & o_Mem_Write_Enable), 32'd0);
      if (o_Mem_Read_Enable) n_reads++;
      if (o_Mem_Write_Enable) begin
         n_writes++;
         w_addr = o_Mem_Write_Address;
         w_data = o_Mem_Write_Data;
         w_cyc  = cyc;
      end
   end

   function automatic int model_c(input int r, input int c, input int kd);
      int s = 0;
      for (int k = 0; k < kd; k++) s += am[r][k] * bm[k][c];
      return s;
   endfunction

   task automatic load_mem(input int ar, input int kd, input int bc);
      for (int r = 0; r < ar; r++)
         for (int k = 0; k < kd; k++) mem[A_BASE + 32'(r * kd + k)] = am[r][k];
      for (int k = 0; k < kd; k++)
         for (int c = 0; c < bc; c++) mem[B_BASE + 32'(k * bc + c)] = bm[k][c];
   endtask

   task automatic rand_mats(input int ar, input int kd, input int bc, input bit big);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            am[i][j] = big ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
            bm[i][j] = big ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
         end
      load_mem(ar, kd, bc);
   endtask

   // One request: accept, optionally poke i_Indexes_Ready at cycle 'poke' after
   // the acknowledge, wait for completion, then check timing, traffic and result.
   task automatic run(input logic [31:0] cfg, input int r, input int c, input int poke);
      int ar, kd, br, bc, ack_cyc;
      bit oor;
      ar  = int'(cfg[7:0]);
      kd  = int'(cfg[15:8]);
      br  = int'(cfg[23:16]);
      bc  = int'(cfg[31:24]);
      oor = (r >= ar) || (c >= bc);
      if (oor || kd != br) err_m = 1'b1;
      n_reads  = 0;
      n_writes = 0;
      @(negedge clk);
      i_Config        = cfg;
      i_Row_Index     = 8'(r);
      i_Column_Index  = 8'(c);
      i_Indexes_Ready = 1'b1;
      #1 check("ack", 32'(o_Indexes_Received), 32'd1);
      ack_cyc = cyc;
      @(negedge clk);
      i_Indexes_Ready = 1'b0;
      #1 check("ack_one_cycle", 32'(o_Indexes_Received), 32'd0);
      for (int n = 0; n < 3 * kd + 8 && !o_Result_Ready; n++) begin
         if (cyc - ack_cyc == poke) begin
            i_Indexes_Ready = 1'b1;
            i_Row_Index     = 8'(c);
            i_Column_Index  = 8'(r);
            #1 check("ack_ignored_busy", 32'(o_Indexes_Received), 32'd0);
         end
         @(negedge clk);
         i_Indexes_Ready = 1'b0;
         #1;
      end
      check("result_ready", 32'(o_Result_Ready), 32'd1);
      check("latency", 32'(cyc - ack_cyc), oor ? 32'd1 : 32'(3 * kd + 2));
      check("error_flag", 32'(o_Error), 32'(err_m));
      check("read_count", 32'(n_reads), oor ? 32'd0 : 32'(2 * kd));
      check("write_count", 32'(n_writes), oor ? 32'd0 : 32'd1);
      if (!oor) begin
         check("wr_addr", w_addr, C_BASE + 32'(r * bc + c));
         check("wr_data", w_data, 32'(model_c(r, c, kd)));
         check("write_before_ready", 32'(w_cyc), 32'(cyc - 1));
      end
      check("idle_enables", {30'd0, o_Mem_Read_Enable, o_Mem_Write_Enable}, 32'd0);
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_ack"},     32'(o_Indexes_Received), 32'd0);
      check({pfx, "_ready"},   32'(o_Result_Ready),     32'd0);
      check({pfx, "_rd_en"},   32'(o_Mem_Read_Enable),  32'd0);
      check({pfx, "_rd_addr"}, o_Mem_Read_Address,      32'd0);
      check({pfx, "_wr_en"},   32'(o_Mem_Write_Enable), 32'd0);
      check({pfx, "_wr_addr"}, o_Mem_Write_Address,     32'd0);
      check({pfx, "_wr_data"}, o_Mem_Write_Data,        32'd0);
      check({pfx, "_error"},   32'(o_Error),            32'd0);
   endtask

   task automatic set_identity_seq;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            am[i][j] = (i == j) ? 1 : 0;
            bm[i][j] = 3 * i + j + 1;
         end
      load_mem(3, 3, 3);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      i_Reset         = 1'b0;
      i_Indexes_Ready = 1'b1;
      i_Config        = 32'h0303_0303;
      i_Row_Index     = 8'd0;
      i_Column_Index  = 8'd0;

      // Held in reset with a request pending: nothing may respond.
      repeat (2) @(negedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      i_Indexes_Ready = 1'b0;
      i_Reset         = 1'b1;
      err_m           = 1'b0;

      // Identity A times B = 1..9: C[1][2] is B[1][2] = 6 at C_BASE+5.
      set_identity_seq();
      run(32'h0303_0303, 1, 2, -1);
      check("identity_value", w_data, 32'd6);

      // Mixed-sign row/column.
      rand_mats(3, 3, 3, 1'b0);
      am[2][0] = -1; am[2][1] = 2;  am[2][2] = 3;
      bm[0][0] = 4;  bm[1][0] = 5;  bm[2][0] = -6;
      load_mem(3, 3, 3);
      run(32'h0303_0303, 2, 0, -1);

      // A new request raised while the unit is in MAC must be ignored.
      rand_mats(3, 3, 3, 1'b0);
      run(32'h0303_0303, 1, 1, 3);

      // Random shapes, half with full-range values to exercise wraparound.
      for (int t = 0; t < 8; t++) begin
         int ar, kd, bc;
         ar = int'($urandom_range(1, 6));
         kd = int'($urandom_range(1, 6));
         bc = int'($urandom_range(1, 6));
         rand_mats(ar, kd, bc, t[0]);
         run({8'(bc), 8'(kd), 8'(kd), 8'(ar)}, int'($urandom_range(0, ar - 1)),
             int'($urandom_range(0, bc - 1)), -1);
      end

      // Empty inner dimension: straight to the write, result zero.
      run(32'h0200_0003, 2, 1, -1);
      check("k0_value", w_data, 32'd0);

      // Inner-dimension mismatch flags an error but still computes with A cols.
      rand_mats(3, 3, 3, 1'b0);
      run(32'h0304_0303, 0, 1, -1);

      // Out-of-range row and column: no traffic, error stays set.
      run(32'h0303_0303, 3, 0, -1);
      run(32'h0303_0303, 0, 3, -1);

      // Reset during READ_B abandons the computation with no write.
      set_identity_seq();
      n_writes = 0;
      @(negedge clk);
      i_Config        = 32'h0303_0303;
      i_Row_Index     = 8'd2;
      i_Column_Index  = 8'd2;
      i_Indexes_Ready = 1'b1;
      #1 check("abort_ack", 32'(o_Indexes_Received), 32'd1);
      @(negedge clk);
      i_Indexes_Ready = 1'b0;
      @(negedge clk);
      #1 check("abort_in_read", 32'(o_Mem_Read_Enable), 32'd1);
      i_Reset = 1'b0;
      err_m   = 1'b0;
      #1 check_all_zero("abort");
      repeat (3) @(negedge clk);
      i_Reset = 1'b1;
      repeat (12) @(negedge clk);
      #1 check("abort_no_write", 32'(n_writes), 32'd0);
      check("abort_ready_low", 32'(o_Result_Ready), 32'd0);

      // The unit is fully usable after the abort.
      run(32'h0303_0303, 2, 2, -1);
      check("post_abort_value", w_data, 32'd9);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
